// File: rtl/afu_copy_pipelined.sv
// Pipelined cache-line copy engine: up to MAX_OUTSTANDING tagged reads in flight,
// each returned line is written to the matching destination offset.
module afu_copy_pipelined #(
  parameter int ADDR_LMT        = 20,
  parameter int MDATA           = 14,
  parameter int CACHE_WIDTH     = 512,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [ADDR_LMT-1:0]    rd_req_addr,
  output logic [MDATA-1:0]       rd_req_mdata,
  output logic                   rd_req_en,
  input  logic                   rd_req_almostfull,
  input  logic                   rd_rsp_valid,
  input  logic [MDATA-1:0]       rd_rsp_mdata,
  input  logic [CACHE_WIDTH-1:0] rd_rsp_data,
  output logic [ADDR_LMT-1:0]    wr_req_addr,
  output logic [MDATA-1:0]       wr_req_mdata,
  output logic [CACHE_WIDTH-1:0] wr_req_data,
  output logic                   wr_req_en,
  input  logic                   wr_req_almostfull,
  input  logic                   wr_rsp0_valid,
  input  logic [MDATA-1:0]       wr_rsp0_mdata,
  input  logic                   wr_rsp1_valid,
  input  logic [MDATA-1:0]       wr_rsp1_mdata,
  input  logic                   start,
  output logic                   done,
  input  logic [511:0]           afu_context
);

  localparam int TAG_W = $clog2(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [1:0] {S_FREE, S_RD_PEND, S_FULL} slot_st_t;

  state_t                 state, state_nxt;
  slot_st_t               slot_st   [MAX_OUTSTANDING];
  logic [ADDR_LMT-1:0]    slot_off  [MAX_OUTSTANDING];
  logic [CACHE_WIDTH-1:0] slot_data [MAX_OUTSTANDING];

  logic [31:0]         num_clines, rd_issued, wr_issued, wr_done_cnt;
  logic [ADDR_LMT-1:0] src_base, dst_base;
  logic                err;

  logic [TAG_W-1:0] rd_slot, wr_slot, rsp_tag;
  logic             rd_found, wr_found, rd_go, wr_go, rsp_hit;

  assign rsp_tag = rd_rsp_mdata[TAG_W-1:0];
  assign rsp_hit = rd_rsp_valid && (slot_st[rsp_tag] == S_RD_PEND);

  // Slot selection: lowest-index FREE slot for reads, lowest-index FULL slot for writes
  always_comb begin
    rd_found = 1'b0;
    rd_slot  = '0;
    wr_found = 1'b0;
    wr_slot  = '0;
    for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
      if (slot_st[i] == S_FREE) begin
        rd_found = 1'b1;
        rd_slot  = TAG_W'(i);
      end
      if (slot_st[i] == S_FULL) begin
        wr_found = 1'b1;
        wr_slot  = TAG_W'(i);
      end
    end
  end

  assign rd_go = (state == RUN) && (rd_issued < num_clines) && rd_found && !rd_req_almostfull;
  assign wr_go = (state == RUN) && wr_found && !wr_req_almostfull;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (afu_context[31:0] == 32'd0) ? DONE : RUN;
      RUN:     if (wr_done_cnt == num_clines) state_nxt = DONE;
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Issue stage: control state, counters and registered request outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      done         <= 1'b0;
      err          <= 1'b0;
      rd_req_en    <= 1'b0;
      wr_req_en    <= 1'b0;
      rd_req_addr  <= '0;
      rd_req_mdata <= '0;
      wr_req_addr  <= '0;
      wr_req_mdata <= '0;
      wr_req_data  <= '0;
      num_clines   <= '0;
      src_base     <= '0;
      dst_base     <= '0;
      rd_issued    <= '0;
      wr_issued    <= '0;
      wr_done_cnt  <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) slot_st[i] <= S_FREE;
    end else begin
      state     <= state_nxt;
      rd_req_en <= rd_go;
      wr_req_en <= wr_go;
      if (state_nxt == DONE) done <= 1'b1;

      if (state == IDLE && start) begin
        num_clines  <= afu_context[31:0];
        src_base    <= afu_context[32 +: ADDR_LMT];
        dst_base    <= afu_context[64 +: ADDR_LMT];
        rd_issued   <= '0;
        wr_issued   <= '0;
        wr_done_cnt <= '0;
      end else begin
        if (rd_go) rd_issued <= rd_issued + 32'd1;
        if (wr_go) wr_issued <= wr_issued + 32'd1;
        wr_done_cnt <= wr_done_cnt + {31'd0, wr_rsp0_valid} + {31'd0, wr_rsp1_valid};
      end

      // The three slot updates below always hit different slots (distinct source states)
      if (rd_go) begin
        rd_req_addr      <= src_base + rd_issued[ADDR_LMT-1:0];
        rd_req_mdata     <= MDATA'(rd_slot);
        slot_st[rd_slot] <= S_RD_PEND;
      end
      if (rd_rsp_valid) begin
        if (rsp_hit) slot_st[rsp_tag] <= S_FULL;
        else         err              <= 1'b1;
      end
      if (wr_go) begin
        wr_req_addr      <= dst_base + slot_off[wr_slot];
        wr_req_data      <= slot_data[wr_slot];
        wr_req_mdata     <= MDATA'(wr_slot);
        slot_st[wr_slot] <= S_FREE;
      end
    end
  end

  // Slot payload storage; contents are only meaningful while the slot is not FREE
  always_ff @(posedge clk) begin
    if (rsp_hit) slot_data[rsp_tag] <= rd_rsp_data;
    if (rd_go)   slot_off[rd_slot]  <= rd_issued[ADDR_LMT-1:0];
  end

  logic unused_sink;
  assign unused_sink = ^{afu_context[511:96], afu_context[63:32+ADDR_LMT],
                         afu_context[95:64+ADDR_LMT], rd_rsp_mdata[MDATA-1:TAG_W],
                         wr_rsp0_mdata, wr_rsp1_mdata, wr_issued, err};

endmodule
